// File: rtl/rsa_seq_ctrl_if.sv
// rtl/rsa_seq_ctrl_if.sv - engine-side bundle between the RSA sequencer and its rtMod/modInv/ModExp engines
// Ports (master = sequencer):
//   rtMod  : rt_go, rt_mode (0=R, 1=T), rt_n -> ; <- rt_r, rt_done
//   modInv : inv_go, inv_n -> ; <- inv_q, inv_valid
//   ModExp : m/e/n/r/t_buf, nprime0, start_input, start_compute, get_result -> ; <- exp_state, res_out
interface rsa_seq_ctrl_if #(
    parameter int WIDTH = 4096,
    parameter int DW    = 64
);
    logic             rt_go;
    logic             rt_mode;
    logic [WIDTH-1:0] rt_n;
    logic [WIDTH-1:0] rt_r;
    logic             rt_done;

    logic             inv_go;
    logic [WIDTH-1:0] inv_n;
    logic [63:0]      inv_q;
    logic             inv_valid;

    logic [DW-1:0]    m_buf;
    logic [DW-1:0]    e_buf;
    logic [DW-1:0]    n_buf;
    logic [DW-1:0]    r_buf;
    logic [DW-1:0]    t_buf;
    logic [63:0]      nprime0;
    logic             start_input;
    logic             start_compute;
    logic             get_result;
    logic [4:0]       exp_state;
    logic [DW-1:0]    res_out;

    modport master (
        output rt_go, rt_mode, rt_n,
        input  rt_r, rt_done,
        output inv_go, inv_n,
        input  inv_q, inv_valid,
        output m_buf, e_buf, n_buf, r_buf, t_buf, nprime0,
        output start_input, start_compute, get_result,
        input  exp_state, res_out
    );

    modport slave (
        input  rt_go, rt_mode, rt_n,
        output rt_r, rt_done,
        input  inv_go, inv_n,
        output inv_q, inv_valid,
        input  m_buf, e_buf, n_buf, r_buf, t_buf, nprime0,
        input  start_input, start_compute, get_result,
        output exp_state, res_out
    );
endinterface

// File: rtl/rsa_seq_ctrl.sv
// rtl/rsa_seq_ctrl.sv - sequencer for m^e mod n: rtMod(R), rtMod(T), modInv, word-serial ModExp load/readback
// Ports:
//   clk, reset           : clock, synchronous active-high reset
//   start                : request, sampled only in IDLE
//   message/exponent/modulus : operands, latched on accepted start
//   busy, done, result   : status, one-cycle completion pulse, result held until next start
//   bus (master)         : engine handshakes, see rsa_seq_ctrl_if
module rsa_seq_ctrl #(
    parameter int WIDTH = 4096,
    parameter int DW    = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     message,
    input  logic [WIDTH-1:0]     exponent,
    input  logic [WIDTH-1:0]     modulus,
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH-1:0]     result,
    rsa_seq_ctrl_if.master       bus
);
    localparam int NW = WIDTH / DW;
    localparam int CW = $clog2(NW) + 1;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_CALC_R   = 3'd1;
    localparam logic [2:0] S_CALC_T   = 3'd2;
    localparam logic [2:0] S_CALC_N0  = 3'd3;
    localparam logic [2:0] S_SEND     = 3'd4;
    localparam logic [2:0] S_WAIT_EXP = 3'd5;
    localparam logic [2:0] S_READ     = 3'd6;
    localparam logic [2:0] S_FINISH   = 3'd7;

    localparam logic [4:0]       EXP_COMPLETE = 5'd9;
    localparam logic [WIDTH-1:0] WORD_MASK    = {{(WIDTH-DW){1'b0}}, {DW{1'b1}}};

    logic [2:0]       state_q, state_d;
    logic [WIDTH-1:0] msg_q, msg_d, exp_q, exp_d, mod_q, mod_d, r_q, r_d, t_q, t_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             rt_go_q, rt_go_d, rt_mode_q, rt_mode_d, inv_go_q, inv_go_d;
    logic [DW-1:0]    m_buf_q, m_buf_d, e_buf_q, e_buf_d, n_buf_q, n_buf_d;
    logic [DW-1:0]    r_buf_q, r_buf_d, t_buf_q, t_buf_d;
    logic [63:0]      nprime0_q, nprime0_d;
    logic             start_input_q, start_input_d;
    logic             start_compute_q, start_compute_d;
    logic             get_result_q, get_result_d;

    function automatic logic [DW-1:0] word_of(input logic [WIDTH-1:0] v, input int idx);
        return DW'(v >> (idx * DW));
    endfunction

    always_comb begin
        state_d         = state_q;
        msg_d           = msg_q;
        exp_d           = exp_q;
        mod_d           = mod_q;
        r_d             = r_q;
        t_d             = t_q;
        result_d        = result_q;
        cnt_d           = cnt_q;
        rt_go_d         = 1'b0;
        rt_mode_d       = rt_mode_q;
        inv_go_d        = 1'b0;
        m_buf_d         = m_buf_q;
        e_buf_d         = e_buf_q;
        n_buf_d         = n_buf_q;
        r_buf_d         = r_buf_q;
        t_buf_d         = t_buf_q;
        nprime0_d       = nprime0_q;
        start_input_d   = start_input_q;
        start_compute_d = start_compute_q;
        get_result_d    = get_result_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    msg_d     = message;
                    exp_d     = exponent;
                    mod_d     = modulus;
                    rt_mode_d = 1'b0;
                    rt_go_d   = 1'b1;
                    state_d   = S_CALC_R;
                end
            end
            // A done seen while our own go pulse is still high belongs to an earlier request.
            S_CALC_R: begin
                if (bus.rt_done && !rt_go_q) begin
                    r_d       = bus.rt_r;
                    rt_mode_d = 1'b1;
                    rt_go_d   = 1'b1;
                    state_d   = S_CALC_T;
                end
            end
            S_CALC_T: begin
                if (bus.rt_done && !rt_go_q) begin
                    t_d      = bus.rt_r;
                    inv_go_d = 1'b1;
                    state_d  = S_CALC_N0;
                end
            end
            // Word 0 is loaded on the way into SEND so that SEND cycle k presents word k.
            S_CALC_N0: begin
                if (bus.inv_valid && !inv_go_q) begin
                    nprime0_d     = bus.inv_q;
                    cnt_d         = '0;
                    m_buf_d       = word_of(msg_q, 0);
                    e_buf_d       = word_of(exp_q, 0);
                    n_buf_d       = word_of(mod_q, 0);
                    r_buf_d       = word_of(r_q, 0);
                    t_buf_d       = word_of(t_q, 0);
                    start_input_d = 1'b1;
                    state_d       = S_SEND;
                end
            end
            S_SEND: begin
                if (cnt_q == CW'(NW - 1)) begin
                    start_input_d   = 1'b0;
                    start_compute_d = 1'b1;
                    get_result_d    = 1'b1;
                    cnt_d           = '0;
                    state_d         = S_WAIT_EXP;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                    m_buf_d = word_of(msg_q, int'(cnt_q) + 1);
                    e_buf_d = word_of(exp_q, int'(cnt_q) + 1);
                    n_buf_d = word_of(mod_q, int'(cnt_q) + 1);
                    r_buf_d = word_of(r_q, int'(cnt_q) + 1);
                    t_buf_d = word_of(t_q, int'(cnt_q) + 1);
                end
            end
            S_WAIT_EXP: begin
                if (bus.exp_state == EXP_COMPLETE) begin
                    cnt_d   = '0;
                    state_d = S_READ;
                end
            end
            // Read cycle 0 is the engine's pipeline fill; cycles 1..NW carry words 0..NW-1.
            S_READ: begin
                if (cnt_q != '0) begin
                    result_d = (result_q & ~(WORD_MASK << ((int'(cnt_q) - 1) * DW)))
                             | (WIDTH'(bus.res_out) << ((int'(cnt_q) - 1) * DW));
                end
                if (cnt_q == CW'(NW)) begin
                    state_d = S_FINISH;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_FINISH: begin
                start_compute_d = 1'b0;
                get_result_d    = 1'b0;
                state_d         = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= S_IDLE;
            msg_q           <= '0;
            exp_q           <= '0;
            mod_q           <= '0;
            r_q             <= '0;
            t_q             <= '0;
            result_q        <= '0;
            cnt_q           <= '0;
            rt_go_q         <= 1'b0;
            rt_mode_q       <= 1'b0;
            inv_go_q        <= 1'b0;
            m_buf_q         <= '0;
            e_buf_q         <= '0;
            n_buf_q         <= '0;
            r_buf_q         <= '0;
            t_buf_q         <= '0;
            nprime0_q       <= '0;
            start_input_q   <= 1'b0;
            start_compute_q <= 1'b0;
            get_result_q    <= 1'b0;
        end else begin
            state_q         <= state_d;
            msg_q           <= msg_d;
            exp_q           <= exp_d;
            mod_q           <= mod_d;
            r_q             <= r_d;
            t_q             <= t_d;
            result_q        <= result_d;
            cnt_q           <= cnt_d;
            rt_go_q         <= rt_go_d;
            rt_mode_q       <= rt_mode_d;
            inv_go_q        <= inv_go_d;
            m_buf_q         <= m_buf_d;
            e_buf_q         <= e_buf_d;
            n_buf_q         <= n_buf_d;
            r_buf_q         <= r_buf_d;
            t_buf_q         <= t_buf_d;
            nprime0_q       <= nprime0_d;
            start_input_q   <= start_input_d;
            start_compute_q <= start_compute_d;
            get_result_q    <= get_result_d;
        end
    end

    assign busy              = (state_q != S_IDLE);
    assign done              = (state_q == S_FINISH);
    assign result            = result_q;
    assign bus.rt_go         = rt_go_q;
    assign bus.rt_mode       = rt_mode_q;
    assign bus.rt_n          = mod_q;
    assign bus.inv_go        = inv_go_q;
    assign bus.inv_n         = mod_q;
    assign bus.m_buf         = m_buf_q;
    assign bus.e_buf         = e_buf_q;
    assign bus.n_buf         = n_buf_q;
    assign bus.r_buf         = r_buf_q;
    assign bus.t_buf         = t_buf_q;
    assign bus.nprime0       = nprime0_q;
    assign bus.start_input   = start_input_q;
    assign bus.start_compute = start_compute_q;
    assign bus.get_result    = get_result_q;
endmodule

// File: tb/tb_rsa_seq_ctrl.sv
// tb/tb_rsa_seq_ctrl.sv - directed self-checking bench for rsa_seq_ctrl with behavioural engine models
module tb_rsa_seq_ctrl;
    localparam int WIDTH = 4096;
    localparam int DW    = 64;
    localparam int NW    = WIDTH / DW;

    localparam logic [WIDTH-1:0] R_VAL = WIDTH'(11);
    localparam logic [WIDTH-1:0] T_VAL = WIDTH'(22);
    localparam logic [63:0]      INV_Q = 64'h1234_5678_9abc_def1;

    logic             clk = 1'b0;
    logic             reset, start;
    logic [WIDTH-1:0] message, exponent, modulus;
    logic             busy, done;
    logic [WIDTH-1:0] result;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    rsa_seq_ctrl_if #(.WIDTH(WIDTH), .DW(DW)) bus ();

    rsa_seq_ctrl #(.WIDTH(WIDTH), .DW(DW)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .message  (message),
        .exponent (exponent),
        .modulus  (modulus),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .bus      (bus)
    );

    function automatic logic [63:0] modexp(input logic [63:0] b, input logic [63:0] e, input logic [63:0] n);
        logic [127:0] r, x;
        if (n == 0) return 64'd0;
        r = 128'd1;
        x = {64'd0, b % n};
        for (int i = 0; i < 64; i++) begin
            if (e[i]) r = (r * x) % {64'd0, n};
            x = (x * x) % {64'd0, n};
        end
        return r[63:0];
    endfunction

    // rtMod model: answers rt_lat cycles after a go pulse; deliberately ignores reset
    int   rt_lat = 1;
    int   rt_cnt = 0;
    logic rt_mode_l = 1'b0;
    always @(posedge clk) begin
        bus.rt_done <= 1'b0;
        if (bus.rt_go) begin
            rt_cnt    <= rt_lat;
            rt_mode_l <= bus.rt_mode;
        end else if (rt_cnt > 0) begin
            rt_cnt <= rt_cnt - 1;
            if (rt_cnt == 1) begin
                bus.rt_done <= 1'b1;
                bus.rt_r    <= rt_mode_l ? T_VAL : R_VAL;
            end
        end
    end

    // modInv model
    int inv_cnt = 0;
    always @(posedge clk) begin
        bus.inv_valid <= 1'b0;
        if (bus.inv_go) begin
            inv_cnt <= 3;
        end else if (inv_cnt > 0) begin
            inv_cnt <= inv_cnt - 1;
            if (inv_cnt == 1) begin
                bus.inv_valid <= 1'b1;
                bus.inv_q     <= INV_Q;
            end
        end
    end

    // ModExp model: records loaded words, reports 8 while computing, 9 when complete,
    // then streams result words two cycles after completion is first seen.
    logic [63:0] mw [NW];
    logic [63:0] ew0, nw0, rw0, tw0;
    int wk = 0, ecnt = 0, rd = 0;
    int exp_lat = 20;
    always @(posedge clk) begin
        if (reset) begin
            wk <= 0; ecnt <= 0; rd <= 0; bus.exp_state <= 5'd0;
        end else if (bus.start_input) begin
            if (wk < NW) mw[wk] <= bus.m_buf;
            if (wk == 0) begin
                ew0 <= bus.e_buf; nw0 <= bus.n_buf; rw0 <= bus.r_buf; tw0 <= bus.t_buf;
            end
            wk <= wk + 1;
            bus.exp_state <= 5'd0;
        end else if (bus.start_compute) begin
            if (bus.exp_state != 5'd9) begin
                if (ecnt >= exp_lat) bus.exp_state <= 5'd9;
                else begin
                    ecnt <= ecnt + 1;
                    bus.exp_state <= 5'd8;
                end
            end else begin
                rd <= rd + 1;
            end
        end else begin
            wk <= 0; ecnt <= 0; rd <= 0; bus.exp_state <= 5'd0;
        end
    end

    always_comb begin
        bus.res_out = '0;
        if (rd >= 2 && rd - 2 < NW)
            bus.res_out = (rd == 2) ? modexp(mw[0], ew0, nw0) : mw[rd - 2];
    end

    // Activity monitor
    logic       clr = 1'b0;
    int         rt_go_cnt = 0, done_cnt = 0, si_cnt = 0;
    logic [7:0] rt_modes = '0;
    always @(posedge clk) begin
        if (clr) begin
            rt_go_cnt <= 0; done_cnt <= 0; si_cnt <= 0; rt_modes <= '0;
        end else begin
            if (bus.rt_go) begin
                rt_go_cnt <= rt_go_cnt + 1;
                rt_modes  <= {rt_modes[6:0], bus.rt_mode};
            end
            if (done) done_cnt <= done_cnt + 1;
            if (bus.start_input) si_cnt <= si_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs[63:0], exp[63:0]);
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_flags"}, WIDTH'({busy, done, bus.rt_go, bus.rt_mode, bus.inv_go,
                                    bus.start_input, bus.start_compute, bus.get_result}), '0);
        chk({tag, "_bufs"}, WIDTH'({bus.m_buf, bus.e_buf, bus.n_buf, bus.r_buf, bus.t_buf}), '0);
        chk({tag, "_nprime0"}, WIDTH'(bus.nprime0), '0);
        chk({tag, "_result"}, result, '0);
    endtask

    task automatic start_op(input logic [WIDTH-1:0] m, input logic [WIDTH-1:0] e, input logic [WIDTH-1:0] n);
        @(negedge clk);
        clr = 1'b1; message = m; exponent = e; modulus = n;
        @(negedge clk);
        clr = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            if (done) break;
            @(negedge clk);
        end
        chk({tag, "_done_seen"}, WIDTH'(done), WIDTH'(1'b1));
    endtask

    task automatic wait_start_input(input string tag);
        int i;
        for (i = 0; i < 2000; i++) begin
            if (bus.start_input) break;
            @(negedge clk);
        end
        chk({tag, "_send_seen"}, WIDTH'(bus.start_input), WIDTH'(1'b1));
    endtask

    initial begin
        logic [WIDTH-1:0] pat;
        int bad;

        reset = 1'b1; start = 1'b0;
        message = '0; exponent = '0; modulus = '0;
        repeat (3) @(negedge clk);
        chk_reset_state("reset");
        reset = 1'b0;

        // Basic run: 8^13 mod 77 = 50
        start_op(WIDTH'(8), WIDTH'(13), WIDTH'(77));
        wait_done("run1", 3000);
        @(negedge clk);
        chk("run1_busy_after_done", WIDTH'(busy), '0);
        chk("run1_result", result, WIDTH'(50));
        repeat (3) @(negedge clk);
        chk("run1_done_count", WIDTH'(done_cnt), WIDTH'(1));
        chk("run1_rt_go_count", WIDTH'(rt_go_cnt), WIDTH'(2));
        chk("run1_rt_modes", WIDTH'(rt_modes[1:0]), WIDTH'(2'b01));
        chk("run1_nprime0", WIDTH'(bus.nprime0), WIDTH'(INV_Q));
        chk("run1_r_word0", WIDTH'(rw0), R_VAL);
        chk("run1_t_word0", WIDTH'(tw0), T_VAL);
        chk("run1_n_word0", WIDTH'(nw0), WIDTH'(77));
        chk("run1_start_input_cycles", WIDTH'(si_cnt), WIDTH'(64));

        // Slow rtMod
        rt_lat = 200;
        start_op(WIDTH'(8), WIDTH'(13), WIDTH'(77));
        wait_done("slow_rt", 3000);
        repeat (2) @(negedge clk);
        chk("slow_rt_result", result, WIDTH'(50));
        chk("slow_rt_rt_go_count", WIDTH'(rt_go_cnt), WIDTH'(2));
        chk("slow_rt_rt_modes", WIDTH'(rt_modes[1:0]), WIDTH'(2'b01));
        rt_lat = 1;

        // start held high across the whole run
        @(negedge clk);
        clr = 1'b1; message = WIDTH'(8); exponent = WIDTH'(13); modulus = WIDTH'(77);
        @(negedge clk);
        clr = 1'b0; start = 1'b1;
        @(negedge clk);
        wait_done("hold", 3000);
        chk("hold_rt_go_count", WIDTH'(rt_go_cnt), WIDTH'(2));
        @(negedge clk);
        chk("hold_idle_after_done", WIDTH'(busy), '0);
        @(negedge clk);
        chk("hold_restart_busy", WIDTH'(busy), WIDTH'(1'b1));
        start = 1'b0;
        wait_done("hold_second", 3000);
        @(negedge clk);
        chk("hold_second_result", result, WIDTH'(50));

        // SEND word ordering: message word k = k+1
        pat = '0;
        for (int k = 0; k < NW; k++) pat[k*DW +: DW] = DW'(k + 1);
        start_op(pat, WIDTH'(13), WIDTH'(77));
        wait_done("pattern", 3000);
        @(negedge clk);
        bad = 0;
        for (int k = 0; k < NW; k++) if (mw[k] !== 64'(k + 1)) bad++;
        chk("pattern_m_buf_words_wrong", WIDTH'(bad), '0);
        chk("pattern_start_input_cycles", WIDTH'(si_cnt), WIDTH'(64));
        chk("pattern_result", result, pat);

        // Reset in SEND cycle 30
        start_op(WIDTH'(8), WIDTH'(13), WIDTH'(77));
        wait_start_input("rst_send");
        repeat (30) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk_reset_state("rst_send");
        repeat (200) @(negedge clk);
        chk("rst_send_no_done", WIDTH'(done_cnt), '0);

        // Reset in READ cycle 10
        start_op(WIDTH'(8), WIDTH'(13), WIDTH'(77));
        for (int i = 0; i < 3000; i++) begin
            if (rd == 11) break;
            @(negedge clk);
        end
        chk("rst_read_reached", WIDTH'(rd), WIDTH'(11));
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk_reset_state("rst_read");
        repeat (100) @(negedge clk);
        chk("rst_read_no_done", WIDTH'(done_cnt), '0);

        // Reset while rtMod is pending: its late rt_done must be ignored
        rt_lat = 20;
        start_op(WIDTH'(8), WIDTH'(13), WIDTH'(77));
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        chk("rst_pending_busy", WIDTH'(busy), '0);
        chk("rst_pending_rt_go_count", WIDTH'(rt_go_cnt), WIDTH'(1));
        rt_lat = 1;

        // Recovery run after resets
        start_op(WIDTH'(8), WIDTH'(13), WIDTH'(77));
        wait_done("recover", 3000);
        @(negedge clk);
        chk("recover_result", result, WIDTH'(50));

        // ModExp never completes: stay in WAIT_EXP
        exp_lat = 5000;
        start_op(WIDTH'(8), WIDTH'(13), WIDTH'(77));
        for (int i = 0; i < 2000; i++) begin
            if (bus.start_compute) break;
            @(negedge clk);
        end
        chk("stall_compute_seen", WIDTH'(bus.start_compute), WIDTH'(1'b1));
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (!busy || done || !bus.start_compute || bus.exp_state !== 5'd8) bad++;
        end
        chk("stall_bad_cycles", WIDTH'(bad), '0);
        chk("stall_no_done", WIDTH'(done_cnt), '0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_lat = 20;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/rsa_seq_ctrl.md
RSA_SEQ_CTRL -- requirements
Module: rsa_seq_ctrl

Interface
REQ-001 Parameter WIDTH, default 4096, operand width in bits.
REQ-002 Parameter DW, default 64, word width of ModExp buffer ports; NW = WIDTH/DW (default 64).
REQ-003 clk  input  1  clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request an exponentiation; sampled only in IDLE.
REQ-006 message / exponent / modulus  input  WIDTH each  operands, captured on accepted start.
REQ-007 busy  output  1  high in every state except IDLE.
REQ-008 done  output  1  one-cycle pulse when result is valid.
REQ-009 result  output  WIDTH  m^e mod n; holds until next accepted start.
REQ-010 rt_go  output  1; rt_mode  output  1 (0=R, 1=T); rt_n  output  WIDTH; rt_r  input  WIDTH; rt_done  input  1  (rtMod side).
REQ-011 inv_go  output  1; inv_n  output  WIDTH; inv_q  input  64; inv_valid  input  1  (modInv side).
REQ-012 m_buf, e_buf, n_buf, r_buf, t_buf  output  DW each; nprime0  output  64; start_input, start_compute, get_result  output  1; exp_state  input  5; res_out  input  DW  (ModExp side).

Function
REQ-013 FSM states: IDLE, CALC_R, CALC_T, CALC_N0, SEND, WAIT_EXP, READ, FINISH.
REQ-014 IDLE: start=1 -> latch message/exponent/modulus, rt_mode<=0, rt_go<=1 for exactly one cycle, go CALC_R; start while busy is ignored.
REQ-015 rt_n and inv_n are driven from the latched modulus at all times.
REQ-016 CALC_R: on rt_done=1 latch rt_r into R, rt_mode<=1, one-cycle rt_go pulse, go CALC_T; rt_done in the same cycle as the go pulse is ignored.
REQ-017 CALC_T: on rt_done=1 latch rt_r into T, one-cycle inv_go pulse, go CALC_N0.
REQ-018 CALC_N0: on inv_valid=1 latch inv_q into nprime0, word counter<=0, go SEND.
REQ-019 SEND: exactly NW cycles; in cycle k (k=0..NW-1) drive m/e/n/r/t_buf with bits [k*DW +: DW] of the latched operands; start_input=1 throughout SEND.
REQ-020 After word NW-1: start_input<=0, start_compute<=1, get_result<=1, go WAIT_EXP; both held high until FINISH.
REQ-021 WAIT_EXP: exp_state==9 (COMPLETE) -> counter<=0, go READ; no timeout.
REQ-022 READ: NW+1 cycles; cycle 0 res_out discarded; cycle j (1..NW) writes res_out into result[(j-1)*DW +: DW].
REQ-023 FINISH: done=1 for one cycle, start_compute/get_result<=0, go IDLE; result not modified.
REQ-024 Word counter is log2(NW)+1 bits wide, never wraps within a phase, cleared on every phase entry.
REQ-025 Unused buffer outputs hold their last value outside SEND; nprime0 stable from CALC_N0 exit to next accepted start.
REQ-026 Total latency start->done = 3 + rtMod(R) + rtMod(T) + modInv + NW + 1 + ModExp compute + NW + 2 cycles.

Reset
REQ-027 reset=1 forces IDLE in the same edge, including mid-operation; pending rt_done/inv_valid afterwards are ignored.
REQ-028 Reset values: busy, done, rt_go, rt_mode, inv_go, start_input, start_compute, get_result = 0; all *_buf, nprime0, result, counter = 0.

Verification
REQ-029 Bench uses behavioural rtMod/modInv/ModExp models with programmable latency.
REQ-030 message=8, exponent=13, modulus=77, default params -> single done pulse, result=50, busy low one cycle after done.
REQ-031 rt_done latency 1 cycle and 200 cycles -> identical result=50, rt_go pulses exactly twice (mode 0 then 1).
REQ-032 start held high across full run -> exactly one operation, then second op begins only after return to IDLE.
REQ-033 SEND monitor with message=WIDTH'h0102..(word k = k+1) -> m_buf equals k+1 in SEND cycle k, 64 cycles, start_input high exactly 64 cycles.
REQ-034 reset asserted in SEND cycle 30 and in READ cycle 10 -> outputs at REQ-028 values next cycle, no done; subsequent run gives result=50.
REQ-035 exp_state held at 8 for 1000 cycles -> controller stays in WAIT_EXP, busy=1, no done.
